// File: rtl/mcu_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_fsm_if
//  Description : Control/handshake bundle between the multi-cycle main
//                control sequencer (master) and the MIPS32 datapath (slave).
//                Ports:
//                  OpCode, Zero, MemReady   datapath -> sequencer
//                  PCWrite .. PCSource      sequencer -> datapath strobes
//                  Trap, State              sequencer status / debug
//  Revision    : 1.0  initial release
// ============================================================================
interface mcu_fsm_if #(
  parameter int OPCODE_LEN = 6,
  parameter int ALUOP_LEN  = 2
);
  logic [OPCODE_LEN-1:0] OpCode;
  logic                  Zero;
  logic                  MemReady;

  logic                  PCWrite;
  logic                  PCWriteCond;
  logic                  IorD;
  logic                  MemRd;
  logic                  MemWr;
  logic                  IRWrite;
  logic                  MemtoReg;
  logic                  RegDst;
  logic                  RegWr;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [ALUOP_LEN-1:0]  ALUOp;
  logic [1:0]            PCSource;
  logic                  Trap;
  logic [3:0]            State;

  modport master (
    input  OpCode, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg,
           RegDst, RegWr, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap, State
  );

  modport slave (
    output OpCode, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg,
           RegDst, RegWr, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap, State
  );
endinterface
`default_nettype wire

// File: rtl/mcu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_fsm
//  Description : Multi-cycle main control sequencer for the MIPS32 core.
//                Steps each instruction through fetch / decode / execute /
//                memory / write-back and decodes datapath strobes from the
//                current state (plus MemReady in FETCH).
//                Ports:
//                  clk   rising-edge clock
//                  rst   synchronous active-high reset (-> FETCH)
//                  bus   mcu_fsm_if.master: OpCode/Zero/MemReady in,
//                        control strobes, Trap and debug State out
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_fsm #(
  parameter int OPCODE_LEN = 6,
  parameter int ALUOP_LEN  = 2
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mcu_fsm_if.master  bus
);

  localparam logic [OPCODE_LEN-1:0] c_OP_RTYPE = OPCODE_LEN'('h00);
  localparam logic [OPCODE_LEN-1:0] c_OP_LW    = OPCODE_LEN'('h23);
  localparam logic [OPCODE_LEN-1:0] c_OP_SW    = OPCODE_LEN'('h2B);
  localparam logic [OPCODE_LEN-1:0] c_OP_BEQ   = OPCODE_LEN'('h04);
  localparam logic [OPCODE_LEN-1:0] c_OP_J     = OPCODE_LEN'('h02);
  localparam logic [OPCODE_LEN-1:0] c_OP_ADDI  = OPCODE_LEN'('h08);

  localparam logic [ALUOP_LEN-1:0] c_ALU_ADD   = ALUOP_LEN'(0);
  localparam logic [ALUOP_LEN-1:0] c_ALU_SUB   = ALUOP_LEN'(1);
  localparam logic [ALUOP_LEN-1:0] c_ALU_FUNCT = ALUOP_LEN'(2);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // MEMADR must pick MEMRD vs MEMWR without re-reading OpCode, which is only
  // sampled on the DECODE exit edge; this bit remembers lw vs sw.
  logic   r_is_load;
  logic   w_is_load_next;

  // Zero gates the PC load in the datapath, not the sequencing here.
  logic   w_unused_zero;
  assign  w_unused_zero = bus.Zero;

  logic                 w_pc_write;
  logic                 w_pc_write_cond;
  logic                 w_iord;
  logic                 w_mem_rd;
  logic                 w_mem_wr;
  logic                 w_ir_write;
  logic                 w_mem_to_reg;
  logic                 w_reg_dst;
  logic                 w_reg_wr;
  logic                 w_alu_src_a;
  logic [1:0]           w_alu_src_b;
  logic [ALUOP_LEN-1:0] w_alu_op;
  logic [1:0]           w_pc_source;
  logic                 w_trap;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_is_load <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_is_load <= w_is_load_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_is_load_next = r_is_load;
    case (r_state)
      FETCH:  if (bus.MemReady) w_state_next = DECODE;
      DECODE: begin
        w_is_load_next = (bus.OpCode == c_OP_LW);
        case (bus.OpCode)
          c_OP_LW,
          c_OP_SW:    w_state_next = MEMADR;
          c_OP_RTYPE: w_state_next = RTEX;
          c_OP_BEQ:   w_state_next = BRANCH;
          c_OP_J:     w_state_next = JUMP;
          c_OP_ADDI:  w_state_next = ADDIEX;
          default:    w_state_next = TRAP;
        endcase
      end
      MEMADR: w_state_next = r_is_load ? MEMRD : MEMWR;
      MEMRD:  if (bus.MemReady) w_state_next = MEMWB;
      MEMWB:  w_state_next = FETCH;
      MEMWR:  if (bus.MemReady) w_state_next = FETCH;
      RTEX:   w_state_next = RTWB;
      RTWB:   w_state_next = FETCH;
      BRANCH: w_state_next = FETCH;
      JUMP:   w_state_next = FETCH;
      ADDIEX: w_state_next = ADDIWB;
      ADDIWB: w_state_next = FETCH;
      TRAP:   w_state_next = TRAP;
      default: w_state_next = FETCH;   // codes 13..15: recover
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore, except IRWrite/PCWrite in FETCH)
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_rd        = 1'b0;
    w_mem_wr        = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_wr        = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = c_ALU_ADD;
    w_pc_source     = 2'b00;
    w_trap          = 1'b0;
    case (r_state)
      FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR.
        w_mem_rd    = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.MemReady;
        w_pc_write  = bus.MemReady;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;              // branch target precompute
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      MEMRD: begin
        w_mem_rd = 1'b1;
        w_iord   = 1'b1;
      end
      MEMWB: begin
        w_reg_wr     = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEMWR: begin
        w_mem_wr = 1'b1;
        w_iord   = 1'b1;
      end
      RTEX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = c_ALU_FUNCT;
      end
      RTWB: begin
        w_reg_wr  = 1'b1;
        w_reg_dst = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = c_ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
      end
      JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      ADDIWB: begin
        w_reg_wr = 1'b1;
      end
      TRAP: begin
        w_trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.PCWrite     = w_pc_write;
  assign bus.PCWriteCond = w_pc_write_cond;
  assign bus.IorD        = w_iord;
  assign bus.MemRd       = w_mem_rd;
  assign bus.MemWr       = w_mem_wr;
  assign bus.IRWrite     = w_ir_write;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.RegDst      = w_reg_dst;
  assign bus.RegWr       = w_reg_wr;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUOp       = w_alu_op;
  assign bus.PCSource    = w_pc_source;
  assign bus.Trap        = w_trap;
  assign bus.State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mcu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_fsm
//  Description : Self-checking bench for mcu_fsm. Random opcode / MemReady /
//                reset stimulus against an instruction-route reference model,
//                plus directed cycle-count, stall, reset and trap scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcu_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcu_fsm_if #(.OPCODE_LEN(6), .ALUOP_LEN(2)) bus ();

  mcu_fsm #(.OPCODE_LEN(6), .ALUOP_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current state code plus the remaining route of the
  // instruction chosen at decode.
  int   cur;
  bit   valid = 1'b0;
  int   path[$];
  logic [3:0] last_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRd,MemWr,IRWrite,MemtoReg,RegDst,RegWr,
  //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],Trap}
  function automatic logic [16:0] obs_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRd, bus.MemWr,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWr, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Trap};
  endfunction

  function automatic logic [16:0] exp_ctrl(input int s, input bit mr);
    logic pcw = 0, pcwc = 0, iord = 0, rd = 0, wr = 0, irw = 0, m2r = 0;
    logic dst = 0, rw = 0, sa = 0, trap = 0;
    logic [1:0] sb = 0, op = 0, pcs = 0;
    case (s)
      0:  begin rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin rd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin wr = 1; iord = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rw = 1; dst = 1; end
      8:  begin sa = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: trap = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, rd, wr, irw, m2r, dst, rw, sa, sb, op, pcs, trap};
  endfunction

  // States visited after DECODE for each opcode.
  function automatic void load_route(input logic [5:0] op);
    path.delete();
    case (op)
      6'h23:   path = '{2, 3, 4};
      6'h2B:   path = '{2, 5};
      6'h00:   path = '{6, 7};
      6'h04:   path = '{8};
      6'h02:   path = '{9};
      6'h08:   path = '{10, 11};
      default: path = '{12};
    endcase
  endfunction

  task automatic cycle(input bit r, input logic [5:0] op, input bit mr);
    @(negedge clk);
    rst          = r;
    bus.OpCode   = op;
    bus.MemReady = mr;
    bus.Zero     = 1'($urandom);
    #1;
    if (valid) begin
      check("state", 32'(bus.State), 32'(cur));
      check("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(cur, mr)));
    end
    last_state = bus.State;
    if (r) begin
      cur = 0; valid = 1'b1; path.delete();
    end else if (valid) begin
      case (cur)
        0:  if (mr) cur = 1;
        1:  begin load_route(op); cur = path.pop_front(); end
        3, 5: if (mr) cur = (path.size() != 0) ? path.pop_front() : 0;
        12: cur = 12;
        default: cur = (path.size() != 0) ? path.pop_front() : 0;
      endcase
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    if ($urandom_range(9) == 0) return 6'($urandom);
    return ops[$urandom_range(5)];
  endfunction

  logic [5:0] cnt_ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
  int         cnt_exp [6] = '{5, 4, 4, 4, 3, 3};

  initial begin
    rst = 1'b1;
    bus.OpCode = '0; bus.MemReady = 1'b0; bus.Zero = 1'b0;
    cycle(1, 6'h00, 1);
    cycle(1, 6'h00, 1);

    // Cycle counts with MemReady tied high, measured on the DUT State.
    for (int k = 0; k < 6; k++) begin
      int n;
      cycle(1, cnt_ops[k], 1);
      cycle(0, cnt_ops[k], 1);
      n = 1;
      while (n < 20) begin
        cycle(0, cnt_ops[k], 1);
        if (last_state == 4'd0) break;
        n++;
      end
      check("cycles", 32'(n), 32'(cnt_exp[k]));
    end

    // FETCH stall then lw, reset held two cycles while waiting in MEMRD.
    cycle(1, 6'h23, 1);
    cycle(0, 6'h23, 0);
    cycle(0, 6'h23, 0);
    cycle(0, 6'h23, 1);
    cycle(0, 6'h23, 1);
    cycle(0, 6'h23, 1);
    cycle(0, 6'h23, 0);
    cycle(1, 6'h23, 0);
    cycle(1, 6'h23, 0);
    cycle(0, 6'h23, 0);
    check("rst_memrd", 32'(last_state), 32'd0);

    // sw with three wait cycles in MEMWR.
    cycle(0, 6'h2B, 1);
    cycle(0, 6'h2B, 1);
    cycle(0, 6'h3F, 1);
    for (int i = 0; i < 3; i++) cycle(0, 6'h3F, 0);
    cycle(0, 6'h3F, 1);
    cycle(0, 6'h3F, 1);
    check("sw_done", 32'(last_state), 32'd0);

    // Illegal opcode traps and holds until reset.
    cycle(0, 6'h3F, 1);
    for (int i = 0; i < 8; i++) cycle(0, rand_op(), 1'($urandom));
    check("trap_hold", 32'(bus.Trap), 32'd1);
    cycle(1, 6'h00, 1);
    cycle(0, 6'h00, 0);
    check("trap_exit", 32'(last_state), 32'd0);

    // Random traffic; OpCode changes every cycle so decode-edge sampling is exercised.
    for (int i = 0; i < 4000; i++) begin
      bit r = ($urandom_range(99) == 0) || (cur == 12 && $urandom_range(7) == 0);
      cycle(r, rand_op(), $urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcu_fsm.md
# mcu_fsm

Multi-cycle main control sequencer for the MIPS32 core. It steps each instruction through fetch, decode, execute, memory and write-back states and drives the datapath control strobes from the current state and `OpCode`. It stalls on a shared-memory ready handshake. The 2-bit `ALUOp` output feeds the existing `alucu` ALU-control decoder unchanged. It replaces the single-cycle combinational main decoder when the core runs in multi-cycle mode.

## Interface
- `OPCODE_LEN`, default 6: opcode width (`OPCODE_LEN` from define.v).
- `ALUOP_LEN`, default 2: ALUOp width (`ALUOP_LEN` from define.v).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `OpCode` input OPCODE_LEN: IR[31:26], valid from DECODE onward.
- `Zero` input 1: ALU zero flag, sampled in BRANCH.
- `MemReady` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: unconditional PC load.
- `PCWriteCond` output 1: PC load gated externally by `Zero`.
- `IorD` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemRd` output 1: memory read request.
- `MemWr` output 1: memory write request.
- `IRWrite` output 1: instruction register load.
- `MemtoReg` output 1: write-back data select, 1 = MDR.
- `RegDst` output 1: destination select, 1 = rd, 0 = rt.
- `RegWr` output 1: register-file write enable.
- `ALUSrcA` output 1: 0 = PC, 1 = rs.
- `ALUSrcB` output 2: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` output ALUOP_LEN: 00 = add, 01 = sub, 10 = decode funct (via `alucu`).
- `PCSource` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Trap` output 1: illegal opcode; stays high while halted.
- `State` output 4: current state code, for debug.

## Operation
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08. Any other opcode goes to TRAP.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12. Codes 13–15 are unreachable; if entered, go to FETCH next cycle with all strobes 0.
- All outputs are 0 unless listed for the state.
- FETCH: `MemRd`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` are 1 only in a cycle where `MemReady`=1. These are the only Mealy outputs in FETCH.
  - Holds in FETCH while `MemReady`=0; moves to DECODE when `MemReady`=1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (precomputes the branch target). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → RTEX
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - anything else → TRAP
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRd`=1, `IorD`=1. Holds until `MemReady`, then MEMWB.
- MEMWB: `RegWr`=1, `MemtoReg`=1, `RegDst`=0. Next FETCH.
- MEMWR: `MemWr`=1, `IorD`=1. Holds until `MemReady`, then FETCH.
- RTEX: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next RTWB.
- RTWB: `RegWr`=1, `RegDst`=1, `MemtoReg`=0. Next FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Next FETCH. This block does not use `Zero` for sequencing; the datapath gates the PC load with it.
- JUMP: `PCWrite`=1, `PCSource`=10. Next FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next ADDIWB.
- ADDIWB: `RegWr`=1, `RegDst`=0, `MemtoReg`=0. Next FETCH.
- TRAP: `Trap`=1, all other strobes 0. Leaves only on `rst`.
- `MemRd` and `MemWr` are never high in the same cycle. `RegWr` is high in exactly one cycle per writing instruction.

## Timing
- Reset: if `rst` is high at a rising edge, state becomes FETCH. This takes priority over any transition, including mid-wait in MEMRD or MEMWR.
  - In the cycle after reset, outputs show FETCH values: `MemRd`=1, `ALUSrcB`=01, everything else 0 except the `MemReady`-gated FETCH strobes.
- State register only; outputs are decoded combinationally from state, plus the FETCH `MemReady` gating.
- Cycle counts with `MemReady` tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each cycle with `MemReady`=0 in FETCH, MEMRD or MEMWR adds one cycle. The request (`MemRd`/`MemWr`) and address select are held stable throughout the wait.
- `OpCode` is sampled only at the DECODE→next edge. Changes at other times have no effect.

## Test plan
- Reset: hold `rst`=1 for 2 cycles during MEMRD → `State`=0 and `MemRd`=1 in the next cycle; `RegWr`=0, `Trap`=0.
- lw with `MemReady`=1 throughout → `State` sequence 0,1,2,3,4,0. `RegWr`=1 with `MemtoReg`=1 only in state 4; `IRWrite` and `PCWrite` pulse once, in cycle 0.
- sw, `MemReady` low for 3 cycles in MEMWR → `State` 5 held 4 cycles with `MemWr`=1, `IorD`=1, then FETCH. `RegWr` is never 1.
- R-type 0x00 then beq 0x04 → `ALUOp`=10 in RTEX; `RegWr`=1 and `RegDst`=1 in RTWB. beq gives `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01 in BRANCH. Total 7 cycles.
- FETCH stall: `MemReady`=0 for 2 cycles, then 1 → `IRWrite`=0 on cycles 1–2 and 1 on cycle 3. Transition to DECODE on cycle 3.
- Illegal opcode 0x3F → `State`=12 and `Trap`=1, held indefinitely with all strobes 0. `rst` returns to FETCH.
